// File: rtl/axi_s2mm_ring_pkg.sv
// Package for the S2MM ring-buffer sequencer.
// Contents: FSM state enum, err_code values, align_up() for descriptor
// lengths and ring_fit(), which decides whether a packet fits in the ring
// and where it starts.
// Ring arithmetic uses a fixed 34-bit width. Any pointer of up to 32 bits
// plus a 17-bit length therefore cannot overflow.
package axi_s2mm_ring_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_LEN,
      ST_CHECK,
      ST_TRIGGER,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_COMMIT,
      ST_HALT
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_OVERSIZE = 2'd1;
   localparam logic [1:0] ERR_SLVERR   = 2'd2;
   localparam logic [1:0] ERR_DECERR   = 2'd3;

   localparam int unsigned RING_W = 34;
   typedef logic [RING_W-1:0] ring_t;

   typedef struct packed {
      logic  fit;    // packet can be placed now
      logic  wrap;   // placement skips the tail and starts at offset 0
      ring_t start;  // start offset of the packet inside the ring
   } fit_t;

   // Rounds (len_m1 + 1) up to a multiple of align (a power of two).
   // The result is 17 bits wide because 65536 must be representable.
   function automatic logic [16:0] align_up(input logic [15:0] len_m1,
                                            input int unsigned align);
      logic [17:0] a;
      logic [17:0] sum;
      a   = 18'(align);
      sum = {2'b00, len_m1} + a;   // (len_m1 + 1) + (align - 1)
      return 17'(sum & ~(a - 18'd1));
   endfunction

   // One slot is always kept free, so wr == rd means the ring is empty.
   // A packet must therefore end strictly before rd.
   function automatic fit_t ring_fit(input ring_t wr, input ring_t rd,
                                     input ring_t size, input ring_t len_al);
      fit_t  r;
      ring_t end_off;
      r       = '0;
      end_off = wr + len_al;
      if (rd > wr) begin
         r.fit   = (end_off < rd);
         r.start = wr;
      end else if (end_off < size) begin
         r.fit   = 1'b1;
         r.start = wr;
      end else if (end_off == size) begin
         // Ending at the buffer end wraps wr to 0. That is only legal when
         // the consumer is not sitting at 0.
         r.fit   = (rd != '0);
         r.start = wr;
      end else begin
         r.wrap  = 1'b1;
         r.fit   = (len_al < rd);
         r.start = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_s2mm_ring_ctl.sv
// axi_s2mm_ring_ctl: sequences axi_s2mm_io so that a packet stream lands in a
// circular buffer in memory.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   enable                 run; a rising edge clears pointers and status
//   cfg_base, cfg_size     ring base address and ring size in bytes
//   rd_ptr                 software consumer offset (flow control)
//   wr_ptr, wrap_ptr       committed producer offset, last wrap-skip offset
//   pkt_count, irq         committed packet count, one-cycle commit pulse
//   halted, err_code       sticky error stop and its cause
//   s_len_*                length descriptor stream (bytes minus one)
//   io_trigger, io_start_addr, io_bytes_to_write
//                          registered command to axi_s2mm_io
//   io_busy, io_response   axi_s2mm_io status; the response is valid when busy falls
// Descriptor handshake: a descriptor transfers on a clock edge where
// s_len_tvalid and s_len_tready are both 1. s_len_tready is high only in
// ST_WAIT_LEN, and it does not depend on s_len_tvalid.
module axi_s2mm_ring_ctl
   import axi_s2mm_ring_pkg::*;
#(
   parameter int unsigned C_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_PTR_WIDTH      = 24,
   parameter int unsigned C_ALIGN          = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [C_AXI_ADDR_WIDTH-1:0] cfg_base,
   input  logic [C_PTR_WIDTH-1:0]      cfg_size,
   input  logic [C_PTR_WIDTH-1:0]      rd_ptr,
   output logic [C_PTR_WIDTH-1:0]      wr_ptr,
   output logic [C_PTR_WIDTH-1:0]      wrap_ptr,
   output logic [31:0]                 pkt_count,
   output logic                        irq,
   output logic                        halted,
   output logic [1:0]                  err_code,
   input  logic [15:0]                 s_len_tdata,
   input  logic                        s_len_tvalid,
   output logic                        s_len_tready,
   output logic                        io_trigger,
   output logic [C_AXI_ADDR_WIDTH-1:0] io_start_addr,
   output logic [15:0]                 io_bytes_to_write,
   input  logic                        io_busy,
   input  logic [1:0]                  io_response
);

   state_e                        state_q;
   logic                          enable_q;
   logic [15:0]                   len_q;
   logic [C_PTR_WIDTH-1:0]        start_q;
   logic                          wrap_q;
   logic [1:0]                    resp_q;
   logic [C_PTR_WIDTH-1:0]        wr_ptr_q;
   logic [C_PTR_WIDTH-1:0]        wrap_ptr_q;
   logic [31:0]                   pkt_count_q;
   logic                          irq_q;
   logic                          halted_q;
   logic [1:0]                    err_code_q;
   logic                          io_trigger_q;
   logic [C_AXI_ADDR_WIDTH-1:0]   io_start_addr_q;
   logic [15:0]                   io_bytes_q;

   logic                          en_rise;
   logic [16:0]                   len_al;
   ring_t                         size_w;
   ring_t                         len_al_w;
   ring_t                         commit_end;
   logic                          oversize;
   fit_t                          fit_d;
   logic [C_PTR_WIDTH-1:0]        wr_ptr_d;

   assign en_rise    = enable & ~enable_q;
   assign len_al     = align_up(len_q, C_ALIGN);
   assign size_w     = ring_t'(cfg_size);
   assign len_al_w   = ring_t'(len_al);
   // One aligned slot must stay free, so the largest packet is size - C_ALIGN.
   assign oversize   = (len_al_w > (size_w - ring_t'(C_ALIGN)));
   assign fit_d      = ring_fit(ring_t'(wr_ptr_q), ring_t'(rd_ptr), size_w, len_al_w);
   assign commit_end = ring_t'(start_q) + len_al_w;
   assign wr_ptr_d   = (commit_end == size_w) ? '0 : C_PTR_WIDTH'(commit_end);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         enable_q        <= 1'b0;
         len_q           <= '0;
         start_q         <= '0;
         wrap_q          <= 1'b0;
         resp_q          <= '0;
         wr_ptr_q        <= '0;
         wrap_ptr_q      <= '0;
         pkt_count_q     <= '0;
         irq_q           <= 1'b0;
         halted_q        <= 1'b0;
         err_code_q      <= ERR_NONE;
         io_trigger_q    <= 1'b0;
         io_start_addr_q <= '0;
         io_bytes_q      <= '0;
      end else begin
         enable_q     <= enable;
         irq_q        <= 1'b0;
         io_trigger_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // The halted flag is cleared by the same edge that sees
               // enable rise, so a rise alone is enough to restart.
               if (enable && (!halted_q || en_rise)) state_q <= ST_WAIT_LEN;
            end
            ST_WAIT_LEN: begin
               // An accepted descriptor is always processed, even if enable
               // dropped in the same cycle.
               if (s_len_tvalid) begin
                  len_q   <= s_len_tdata;
                  state_q <= ST_CHECK;
               end else if (!enable) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               // Re-evaluated every cycle, so a moving rd_ptr unblocks us.
               if (oversize) begin
                  err_code_q <= ERR_OVERSIZE;
                  halted_q   <= 1'b1;
                  state_q    <= ST_HALT;
               end else if (fit_d.fit) begin
                  start_q         <= C_PTR_WIDTH'(fit_d.start);
                  wrap_q          <= fit_d.wrap;
                  io_start_addr_q <= cfg_base + C_AXI_ADDR_WIDTH'(fit_d.start);
                  io_bytes_q      <= len_q;
                  io_trigger_q    <= 1'b1;
                  state_q         <= ST_TRIGGER;
               end
            end
            ST_TRIGGER:   state_q <= ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (io_busy) state_q <= ST_WAIT_DONE;
            ST_WAIT_DONE: begin
               if (!io_busy) begin
                  resp_q  <= io_response;
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               // The data was written whatever the response, so the packet
               // is committed before the error stops the ring.
               wr_ptr_q    <= wr_ptr_d;
               if (wrap_q) wrap_ptr_q <= wr_ptr_q;
               irq_q       <= 1'b1;
               pkt_count_q <= pkt_count_q + 32'd1;
               if (resp_q[1]) begin
                  halted_q   <= 1'b1;
                  err_code_q <= resp_q;
                  state_q    <= ST_HALT;
               end else if (enable) begin
                  state_q <= ST_WAIT_LEN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HALT:  if (!enable) state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
         // A fresh enable overrides any update made above in this cycle.
         if (en_rise) begin
            wr_ptr_q    <= '0;
            wrap_ptr_q  <= '0;
            pkt_count_q <= '0;
            halted_q    <= 1'b0;
            err_code_q  <= ERR_NONE;
         end
      end
   end

   assign s_len_tready      = (state_q == ST_WAIT_LEN);
   assign wr_ptr            = wr_ptr_q;
   assign wrap_ptr          = wrap_ptr_q;
   assign pkt_count         = pkt_count_q;
   assign irq               = irq_q;
   assign halted            = halted_q;
   assign err_code          = err_code_q;
   assign io_trigger        = io_trigger_q;
   assign io_start_addr     = io_start_addr_q;
   assign io_bytes_to_write = io_bytes_q;

endmodule

// File: tb/tb_axi_s2mm_ring_ctl.sv
// Directed bench for axi_s2mm_ring_ctl with a behavioural axi_s2mm_io model:
// busy rises on the negedge after a trigger, stays high for busy_len
// negedges, then falls together with the response.
module tb_axi_s2mm_ring_ctl;

   localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [63:0] cfg_base;
   logic [23:0] cfg_size;
   logic [23:0] rd_ptr;
   logic [23:0] wr_ptr;
   logic [23:0] wrap_ptr;
   logic [31:0] pkt_count;
   logic        irq;
   logic        halted;
   logic [1:0]  err_code;
   logic [15:0] s_len_tdata;
   logic        s_len_tvalid;
   logic        s_len_tready;
   logic        io_trigger;
   logic [63:0] io_start_addr;
   logic [15:0] io_bytes_to_write;
   logic        io_busy;
   logic [1:0]  io_response;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          trig_cnt = 0;
   int          busy_len = 4;
   int          busy_cnt = 0;
   logic [1:0]  resp_next = 2'd0;
   logic [63:0] addr_q[$];
   logic [15:0] bytes_q[$];

   axi_s2mm_ring_ctl #(
      .C_AXI_ADDR_WIDTH(64),
      .C_PTR_WIDTH(24),
      .C_ALIGN(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .cfg_base(cfg_base), .cfg_size(cfg_size), .rd_ptr(rd_ptr),
      .wr_ptr(wr_ptr), .wrap_ptr(wrap_ptr), .pkt_count(pkt_count),
      .irq(irq), .halted(halted), .err_code(err_code),
      .s_len_tdata(s_len_tdata), .s_len_tvalid(s_len_tvalid),
      .s_len_tready(s_len_tready), .io_trigger(io_trigger),
      .io_start_addr(io_start_addr), .io_bytes_to_write(io_bytes_to_write),
      .io_busy(io_busy), .io_response(io_response)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // axi_s2mm_io model
   initial begin
      io_busy     = 1'b0;
      io_response = 2'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            io_busy  = 1'b0;
            busy_cnt = 0;
         end else if (io_busy) begin
            if (busy_cnt <= 1) begin
               io_busy     = 1'b0;
               io_response = resp_next;
            end else begin
               busy_cnt--;
            end
         end else if (io_trigger) begin
            io_busy  = 1'b1;
            busy_cnt = busy_len;
            trig_cnt++;
            addr_q.push_back(io_start_addr);
            bytes_q.push_back(io_bytes_to_write);
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_len(input string tag, input logic [15:0] len);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      s_len_tdata  = len;
      s_len_tvalid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (s_len_tready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      s_len_tvalid = 1'b0;
      check_val({tag, "_accept"}, ok, 1);
   endtask

   task automatic wait_irq(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (irq) begin
            seen = 1'b1;
            break;
         end
      end
      check_val({tag, "_irq"}, seen, 1);
   endtask

   task automatic pop_trig(input string tag, input logic [63:0] exp_addr, input logic [15:0] exp_bytes);
      check_val({tag, "_ntrig"}, addr_q.size(), 1);
      if (addr_q.size() > 0) begin
         check_val({tag, "_addr"}, addr_q.pop_front(), exp_addr);
         check_val({tag, "_bytes"}, bytes_q.pop_front(), exp_bytes);
      end
   endtask

   task automatic do_pkt(input string tag, input logic [15:0] len, input logic [63:0] exp_addr);
      send_len(tag, len);
      wait_irq(tag);
      pop_trig(tag, exp_addr, len);
   endtask

   task automatic toggle_enable();
      @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
   endtask

   int t0;
   logic tr_seen;

   initial begin
      rst_n        = 1'b0;
      enable       = 1'b0;
      cfg_base     = BASE;
      cfg_size     = 24'h1000;
      rd_ptr       = 24'h0;
      s_len_tdata  = 16'h0;
      s_len_tvalid = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check_val("rst_wr_ptr", wr_ptr, 0);
      check_val("rst_wrap_ptr", wrap_ptr, 0);
      check_val("rst_pkt_count", pkt_count, 0);
      check_val("rst_irq", irq, 0);
      check_val("rst_halted", halted, 0);
      check_val("rst_err", err_code, 0);
      check_val("rst_tready", s_len_tready, 0);
      check_val("rst_trigger", io_trigger, 0);
      check_val("rst_addr", io_start_addr, 0);
      check_val("rst_bytes", io_bytes_to_write, 0);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;

      // two 64-byte packets back to back
      do_pkt("p1", 16'd63, BASE + 64'h000);
      check_val("p1_wr", wr_ptr, 24'h040);
      @(negedge clk);
      check_val("irq_one_cycle", irq, 0);
      do_pkt("p2", 16'd63, BASE + 64'h040);
      check_val("p2_wr", wr_ptr, 24'h080);
      check_val("p2_cnt", pkt_count, 2);
      check_val("p2_ntrig_total", trig_cnt, 2);

      // fill to 0xFC0, then a packet that must skip to base
      do_pkt("fill1", 16'h0F3F, BASE + 64'h080);
      check_val("fill1_wr", wr_ptr, 24'hFC0);
      rd_ptr = 24'h800;
      do_pkt("wrap", 16'd127, BASE + 64'h000);
      check_val("wrap_wrap_ptr", wrap_ptr, 24'hFC0);
      check_val("wrap_wr", wr_ptr, 24'h080);
      check_val("wrap_cnt", pkt_count, 4);

      // end would touch rd_ptr exactly: stall until rd moves
      do_pkt("fill2", 16'd127, BASE + 64'h080);
      check_val("fill2_wr", wr_ptr, 24'h100);
      rd_ptr = 24'h140;
      t0 = trig_cnt;
      send_len("stall_rd", 16'd63);
      repeat (10) @(negedge clk);
      check_val("stall_rd_notrig", trig_cnt - t0, 0);
      check_val("stall_rd_tready", s_len_tready, 0);
      rd_ptr = 24'h150;
      @(negedge clk);
      check_val("stall_rd_trig_next", io_trigger, 1);
      wait_irq("stall_rd");
      pop_trig("stall_rd", BASE + 64'h100, 16'd63);
      check_val("stall_rd_wr", wr_ptr, 24'h140);

      // end exactly at size while rd = 0: stall, then wr wraps to 0
      rd_ptr = 24'h0;
      do_pkt("fill3", 16'h0E7F, BASE + 64'h140);
      check_val("fill3_wr", wr_ptr, 24'hFC0);
      t0 = trig_cnt;
      send_len("stall_end", 16'd63);
      repeat (10) @(negedge clk);
      check_val("stall_end_notrig", trig_cnt - t0, 0);
      rd_ptr = 24'h040;
      wait_irq("stall_end");
      pop_trig("stall_end", BASE + 64'hFC0, 16'd63);
      check_val("stall_end_wr", wr_ptr, 24'h000);
      check_val("stall_end_wrap_ptr", wrap_ptr, 24'hFC0);
      check_val("stall_end_cnt", pkt_count, 8);

      // SLVERR: packet commits, then halt
      resp_next = 2'd2;
      do_pkt("slverr", 16'd15, BASE + 64'h000);
      check_val("slverr_halted", halted, 1);
      check_val("slverr_err", err_code, 2);
      check_val("slverr_wr", wr_ptr, 24'h010);
      check_val("slverr_cnt", pkt_count, 9);
      resp_next = 2'd0;
      s_len_tvalid = 1'b1;
      tr_seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (s_len_tready) tr_seen = 1'b1;
      end
      s_len_tvalid = 1'b0;
      check_val("slverr_no_tready", tr_seen, 0);
      toggle_enable();
      check_val("clr_wr", wr_ptr, 0);
      check_val("clr_wrap", wrap_ptr, 0);
      check_val("clr_cnt", pkt_count, 0);
      check_val("clr_halted", halted, 0);
      check_val("clr_err", err_code, 0);
      rd_ptr = 24'h0;
      do_pkt("resume", 16'd63, BASE + 64'h000);
      check_val("resume_wr", wr_ptr, 24'h040);
      check_val("resume_cnt", pkt_count, 1);

      // oversize descriptor: 4096 B in a 4096 B ring
      t0 = trig_cnt;
      send_len("oversize", 16'h0FFF);
      repeat (10) @(negedge clk);
      check_val("oversize_halted", halted, 1);
      check_val("oversize_err", err_code, 1);
      check_val("oversize_notrig", trig_cnt - t0, 0);
      check_val("oversize_tready", s_len_tready, 0);
      toggle_enable();
      check_val("clr2_halted", halted, 0);

      // reset during ST_WAIT_DONE
      do_pkt("pre_rst", 16'd63, BASE + 64'h000);
      busy_len = 20;
      send_len("mid_rst", 16'd63);
      tr_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (io_busy) begin
            tr_seen = 1'b1;
            break;
         end
      end
      check_val("mid_rst_busy", tr_seen, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_rst_wr", wr_ptr, 0);
      check_val("mid_rst_cnt", pkt_count, 0);
      check_val("mid_rst_trigger", io_trigger, 0);
      check_val("mid_rst_addr", io_start_addr, 0);
      check_val("mid_rst_irq", irq, 0);
      check_val("mid_rst_halted", halted, 0);
      pop_trig("mid_rst", BASE + 64'h040, 16'd63);
      rst_n = 1'b1;
      busy_len = 4;
      @(negedge clk);
      do_pkt("post_rst", 16'd63, BASE + 64'h000);
      check_val("post_rst_wr", wr_ptr, 24'h040);
      check_val("post_rst_cnt", pkt_count, 1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
